// File: rtl/noc_pkg.sv
// Shared types for the NoC target network interface: opcodes, status codes and the
// header body that sits above the dst/src node-id fields.
package noc_pkg;

    typedef enum logic [1:0] {
        OP_WR     = 2'd0,
        OP_RD     = 2'd1,
        OP_WR_ACK = 2'd2,
        OP_RD_RSP = 2'd3
    } noc_op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_ADDR_ERR = 2'd1,
        ST_LEN_ERR  = 2'd2,
        ST_RSVD     = 2'd3
    } noc_status_e;

    // Header body, LSB-up: op, len, tag, status, addr. It starts at bit 2*NID_W.
    typedef struct packed {
        logic [31:0] addr;
        noc_status_e status;
        logic [3:0]  tag;
        logic [7:0]  len;
        noc_op_e     op;
    } noc_hdr_t;

    localparam int HDR_BODY_W = 48;
    localparam int OFF_OP     = 0;
    localparam int OFF_LEN    = 2;
    localparam int OFF_TAG    = 10;
    localparam int OFF_STATUS = 14;
    localparam int OFF_ADDR   = 16;

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle (tvalid/tready/tdata/tlast) used for NoC flit links.
interface axi4_stream_if #(parameter int DW = 64) ();
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport Master (output tvalid, output tdata, output tlast, input tready);
    modport Slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/noc_rsp_fifo.sv
// Two-entry valid/ready FIFO holding {tlast,tdata}; a push is accepted while full
// if the head is popped in the same cycle.
module noc_rsp_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   cnt_r;
    logic         push_s;
    logic         pop_s;

    assign out_valid = (cnt_r != 2'd0);
    assign in_ready  = (cnt_r != 2'd2) || out_ready;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = cnt_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

// File: rtl/noc_tgt_ni.sv
// Target-side NoC network interface: decodes request packets, performs SRAM
// reads/writes and returns WR_ACK / RD_RSP packets through a 2-entry FIFO.
module noc_tgt_ni
    import noc_pkg::*;
#(
    parameter int NODE_ID = 0,
    parameter int NID_W   = 4,
    parameter int DW      = 64,
    parameter int AW      = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    axi4_stream_if.Slave  req_i,
    axi4_stream_if.Master rsp_o,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   drop_cnt
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_DATA  = 3'd1,
        S_WR_ACK   = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_DROP     = 3'd4
    } state_e;

    localparam logic [NID_W-1:0] NODE_ID_L = NID_W'(NODE_ID);
    localparam logic [32:0]      MEM_LIMIT = 33'd1 << AW;

    state_e            state_r, state_n_s;
    noc_hdr_t          hdr_r, hdr_n_s;
    logic [NID_W-1:0]  src_r, src_n_s;
    noc_status_e       status_r, status_n_s, wr_status_s;
    logic [8:0]        beat_r, beat_n_s;
    logic [8:0]        issue_r, issue_n_s;
    logic              hdr_sent_r, hdr_sent_n_s;
    logic              inflight_r, inflight_n_s;
    logic              infl_last_r, infl_last_n_s;
    logic              rd_err_r, rd_err_n_s;
    logic              run_r;
    logic [15:0]       drop_cnt_r;
    logic              drop_inc_s;

    noc_hdr_t          hdr_in_s;
    logic [NID_W-1:0]  dst_in_s, src_in_s;
    logic              req_fire_s;
    logic [32:0]       wr_addr_s, rd_end_s;
    logic [AW-1:0]     rd_addr_s;
    logic              push_valid_s, push_ready_s, push_last_s, pop_s;
    logic [DW-1:0]     push_data_s;
    logic [DW:0]       fifo_out_s;
    logic [1:0]        fifo_cnt_s;
    logic              rsp_valid_s;
    logic              credit_ok_s;

    // Builds a response header addressed back to the requester.
    function automatic logic [DW-1:0] rsp_hdr(input noc_hdr_t req, input logic [NID_W-1:0] dst,
                                              input noc_op_e op, input noc_status_e st);
        noc_hdr_t        b;
        logic [DW-1:0]   w;
        b        = req;
        b.op     = op;
        b.status = st;
        w        = '0;
        w[NID_W-1:0]            = dst;
        w[2*NID_W-1:NID_W]      = NODE_ID_L;
        w[2*NID_W +: HDR_BODY_W] = b;
        return w;
    endfunction

    assign hdr_in_s   = noc_hdr_t'(req_i.tdata[2*NID_W +: HDR_BODY_W]);
    assign dst_in_s   = req_i.tdata[NID_W-1:0];
    assign src_in_s   = req_i.tdata[2*NID_W-1:NID_W];
    assign req_fire_s = req_i.tvalid && req_i.tready;
    assign wr_addr_s  = {1'b0, hdr_r.addr} + {24'd0, beat_r};
    assign rd_end_s   = {1'b0, hdr_in_s.addr} + {25'd0, hdr_in_s.len};
    assign rd_addr_s  = hdr_r.addr[AW-1:0] + AW'(issue_r);
    assign pop_s      = rsp_valid_s && rsp_o.tready;
    // A read issued now lands next cycle; it needs a slot after this cycle's push/pop.
    assign credit_ok_s = (({1'b0, fifo_cnt_s} + {2'b00, inflight_r}) - {2'b00, pop_s}) < 3'd2;

    // Next-state, SRAM strobes, request back-pressure and response pushes.
    always_comb begin
        state_n_s     = state_r;
        hdr_n_s       = hdr_r;
        src_n_s       = src_r;
        status_n_s    = status_r;
        wr_status_s   = status_r;
        beat_n_s      = beat_r;
        issue_n_s     = issue_r;
        hdr_sent_n_s  = hdr_sent_r;
        inflight_n_s  = 1'b0;
        infl_last_n_s = 1'b0;
        rd_err_n_s    = rd_err_r;
        drop_inc_s    = 1'b0;
        req_i.tready  = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        push_valid_s  = 1'b0;
        push_data_s   = '0;
        push_last_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                req_i.tready = run_r;
                if (req_fire_s) begin
                    hdr_n_s      = hdr_in_s;
                    src_n_s      = src_in_s;
                    status_n_s   = ST_OK;
                    beat_n_s     = 9'd0;
                    issue_n_s    = 9'd0;
                    hdr_sent_n_s = 1'b0;
                    if (dst_in_s != NODE_ID_L) begin
                        drop_inc_s = 1'b1;
                        state_n_s  = req_i.tlast ? S_IDLE : S_DROP;
                    end else if (hdr_in_s.op == OP_WR) begin
                        status_n_s = req_i.tlast ? ST_LEN_ERR : ST_OK;
                        state_n_s  = req_i.tlast ? S_WR_ACK : S_WR_DATA;
                    end else if (hdr_in_s.op == OP_RD) begin
                        rd_err_n_s = !(rd_end_s < MEM_LIMIT);
                        state_n_s  = S_RD_ISSUE;
                    end else begin
                        state_n_s = req_i.tlast ? S_IDLE : S_DROP;
                    end
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_WR_DATA: begin
                req_i.tready = 1'b1;
                if (req_fire_s) begin
                    if (beat_r <= {1'b0, hdr_r.len} && wr_addr_s < MEM_LIMIT) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = wr_addr_s[AW-1:0];
                        mem_wdata = req_i.tdata;
                    end else if (beat_r <= {1'b0, hdr_r.len} && status_r == ST_OK) begin
                        wr_status_s = ST_ADDR_ERR;
                    end else begin
                        wr_status_s = status_r;
                    end
                    // LEN_ERR wins over ADDR_ERR: it says the whole packet is malformed.
                    if (req_i.tlast != (beat_r == {1'b0, hdr_r.len})) begin
                        wr_status_s = ST_LEN_ERR;
                    end else begin
                        wr_status_s = wr_status_s;
                    end
                    status_n_s = wr_status_s;
                    beat_n_s   = (beat_r == 9'h100) ? beat_r : beat_r + 9'd1;
                    if (req_i.tlast) begin
                        push_valid_s = 1'b1;
                        push_last_s  = 1'b1;
                        push_data_s  = rsp_hdr(hdr_r, src_r, OP_WR_ACK, wr_status_s);
                        state_n_s    = push_ready_s ? S_IDLE : S_WR_ACK;
                    end else begin
                        state_n_s = S_WR_DATA;
                    end
                end else begin
                    state_n_s = S_WR_DATA;
                end
            end
            S_WR_ACK: begin
                push_valid_s = 1'b1;
                push_last_s  = 1'b1;
                push_data_s  = rsp_hdr(hdr_r, src_r, OP_WR_ACK, status_r);
                state_n_s    = push_ready_s ? S_IDLE : S_WR_ACK;
            end
            S_RD_ISSUE: begin
                if (!hdr_sent_r) begin
                    push_valid_s = 1'b1;
                    push_data_s  = rsp_hdr(hdr_r, src_r, OP_RD_RSP,
                                           rd_err_r ? ST_ADDR_ERR : ST_OK);
                    hdr_sent_n_s = push_ready_s;
                end else begin
                    push_valid_s = inflight_r;
                    push_data_s  = rd_err_r ? '0 : mem_rdata;
                    push_last_s  = infl_last_r;
                    if (issue_r <= {1'b0, hdr_r.len} && credit_ok_s) begin
                        mem_en        = !rd_err_r;
                        mem_addr      = rd_addr_s;
                        inflight_n_s  = 1'b1;
                        infl_last_n_s = (issue_r == {1'b0, hdr_r.len});
                        issue_n_s     = issue_r + 9'd1;
                    end else begin
                        issue_n_s = issue_r;
                    end
                    state_n_s = (inflight_r && infl_last_r) ? S_IDLE : S_RD_ISSUE;
                end
            end
            S_DROP: begin
                req_i.tready = 1'b1;
                state_n_s    = (req_fire_s && req_i.tlast) ? S_IDLE : S_DROP;
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
    end

    // FSM state, latched header and per-packet counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            hdr_r       <= '0;
            src_r       <= '0;
            status_r    <= ST_OK;
            beat_r      <= 9'd0;
            issue_r     <= 9'd0;
            hdr_sent_r  <= 1'b0;
            inflight_r  <= 1'b0;
            infl_last_r <= 1'b0;
            rd_err_r    <= 1'b0;
            run_r       <= 1'b0;
            drop_cnt_r  <= 16'd0;
        end else begin
            state_r     <= state_n_s;
            hdr_r       <= hdr_n_s;
            src_r       <= src_n_s;
            status_r    <= status_n_s;
            beat_r      <= beat_n_s;
            issue_r     <= issue_n_s;
            hdr_sent_r  <= hdr_sent_n_s;
            inflight_r  <= inflight_n_s;
            infl_last_r <= infl_last_n_s;
            rd_err_r    <= rd_err_n_s;
            run_r       <= 1'b1;
            if (drop_inc_s && drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign drop_cnt     = drop_cnt_r;
    assign rsp_o.tvalid = rsp_valid_s;
    assign rsp_o.tlast  = fifo_out_s[DW];
    assign rsp_o.tdata  = fifo_out_s[DW-1:0];

    noc_rsp_fifo #(.W(DW + 1)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid_s),
        .in_ready  (push_ready_s),
        .in_data   ({push_last_s, push_data_s}),
        .out_valid (rsp_valid_s),
        .out_ready (rsp_o.tready),
        .out_data  (fifo_out_s),
        .count     (fifo_cnt_s)
    );
endmodule

// File: tb/tb_noc_tgt_ni.sv
// Scoreboard bench for noc_tgt_ni: expected response flits are queued when requests
// are driven and compared as the DUT emits them; a behavioural SRAM backs the port.
module tb_noc_tgt_ni;
    logic        clk;
    logic        rst_n;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [15:0] drop_cnt;
    logic        tog;

    bit   [63:0] smem [1024];
    int          wr_cnt, en_cnt, cyc;
    int          vectors, miscompares;
    logic [64:0] exp_d [$];
    logic [64:0] exp_m [$];

    localparam logic [64:0] M_ACK  = 65'h1_0000_0000_00FC_03FF;
    localparam logic [64:0] M_RD   = 65'h1_0000_0000_00FF_FFFF;
    localparam logic [64:0] M_DATA = {65{1'b1}};
    localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A, DB = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] DC = 64'hCCCC_0000_0000_000C, DD = 64'hDDDD_0000_0000_000D;
    localparam logic [63:0] DE = 64'hEEEE_1111_2222_3333, DF = 64'hFFFF_4444_5555_6666;
    localparam logic [63:0] DG = 64'h1234_5678_9ABC_DEF0;

    axi4_stream_if #(.DW(64)) req_if ();
    axi4_stream_if #(.DW(64)) rsp_if ();

    noc_tgt_ni #(.NODE_ID(0), .NID_W(4), .DW(64), .AW(10)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_if), .rsp_o(rsp_if),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) begin
                smem[mem_addr] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                mem_rdata <= smem[mem_addr];
            end
        end
    end

    // Response-side ready: steady high, or alternating 1010 when tog is set.
    initial begin
        rsp_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rsp_if.tready = tog ? ~rsp_if.tready : 1'b1;
        end
    end

    // Scoreboard: every accepted response flit is checked against the queue head.
    always @(negedge clk) begin
        if (rst_n && rsp_if.tvalid && rsp_if.tready) begin
            vectors++;
            if (exp_d.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected got=%h required=none", {rsp_if.tlast, rsp_if.tdata});
            end else begin
                logic [64:0] e, m;
                e = exp_d.pop_front();
                m = exp_m.pop_front();
                if ((({rsp_if.tlast, rsp_if.tdata} ^ e) & m) != 65'd0) begin
                    miscompares++;
                    $display("FAIL rsp_flit got=%h required=%h mask=%h",
                             {rsp_if.tlast, rsp_if.tdata}, e, m);
                end
            end
        end
    end

    function automatic logic [63:0] mkhdr(input logic [3:0] dst, input logic [3:0] src,
                                          input logic [1:0] op, input logic [7:0] len,
                                          input logic [3:0] tag, input logic [1:0] st,
                                          input logic [31:0] addr);
        logic [63:0] h;
        h = 64'd0;
        h[3:0] = dst; h[7:4] = src; h[9:8] = op; h[17:10] = len;
        h[21:18] = tag; h[23:22] = st; h[55:24] = addr;
        return h;
    endfunction

    task automatic expect_flit(input logic last, input logic [63:0] d, input logic [64:0] m);
        exp_d.push_back({last, d});
        exp_m.push_back(m);
    endtask

    task automatic send(input logic [63:0] d, input logic last);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        req_if.tvalid = 1'b1;
        req_if.tdata  = d;
        req_if.tlast  = last;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = req_if.tready;
            @(posedge clk);
            #1;
            n++;
        end
        req_if.tvalid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout got=no_tready required=accept");
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (exp_d.size() != 0) begin
            miscompares++;
            $display("FAIL drain_%s got=%0d pending required=0", name, exp_d.size());
            exp_d.delete();
            exp_m.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_if.tvalid = 1'b0; req_if.tdata = 64'd0; req_if.tlast = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 4;
        if (rsp_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_tvalid got=%b required=0", rsp_if.tvalid); end
        if (req_if.tready !== 1'b0) begin miscompares++; $display("FAIL reset_req_tready got=%b required=0", req_if.tready); end
        if (mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en got=%b required=0", mem_en); end
        if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop_cnt got=%0d required=0", drop_cnt); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        int w0;
        logic [63:0] data [4];
        data[0] = DA; data[1] = DB; data[2] = DC; data[3] = DD;
        w0 = wr_cnt;
        expect_flit(1'b1, mkhdr(4'd2, 4'd0, 2'd2, 8'd0, 4'd7, 2'd0, 32'd0), M_ACK);
        send(mkhdr(4'd0, 4'd2, 2'd0, 8'd3, 4'd7, 2'd0, 32'd5), 1'b0);
        for (int i = 0; i < 4; i++) send(data[i], i == 3);
        vectors++;
        if (rsp_if.tvalid !== 1'b1) begin miscompares++; $display("FAIL wr_ack_latency got=%b required=1", rsp_if.tvalid); end
        wait_drain("write");
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (smem[5 + i] !== data[i]) begin miscompares++; $display("FAIL wr_sram_%0d got=%h required=%h", 5 + i, smem[5 + i], data[i]); end
        end
        vectors++;
        if (wr_cnt - w0 != 4) begin miscompares++; $display("FAIL wr_count got=%0d required=4", wr_cnt - w0); end
    endtask

    task automatic test_read_toggle();
        tog = 1'b1;
        expect_flit(1'b0, mkhdr(4'd3, 4'd0, 2'd3, 8'd3, 4'd9, 2'd0, 32'd0), M_RD);
        expect_flit(1'b0, DA, M_DATA);
        expect_flit(1'b0, DB, M_DATA);
        expect_flit(1'b0, DC, M_DATA);
        expect_flit(1'b1, DD, M_DATA);
        send(mkhdr(4'd0, 4'd3, 2'd1, 8'd3, 4'd9, 2'd0, 32'd5), 1'b1);
        wait_drain("read_toggle");
        tog = 1'b0;
    endtask

    task automatic test_out_of_range();
        int e0, w0;
        e0 = en_cnt;
        expect_flit(1'b0, mkhdr(4'd1, 4'd0, 2'd3, 8'd3, 4'd4, 2'd1, 32'd0), M_RD);
        for (int i = 0; i < 4; i++) expect_flit(i == 3, 64'd0, M_DATA);
        send(mkhdr(4'd0, 4'd1, 2'd1, 8'd3, 4'd4, 2'd0, 32'd1022), 1'b1);
        wait_drain("rd_oob");
        vectors++;
        if (en_cnt != e0) begin miscompares++; $display("FAIL rd_oob_mem_en got=%0d required=0", en_cnt - e0); end
        // Write straddling the top word: only the in-range beat lands.
        w0 = wr_cnt;
        expect_flit(1'b1, mkhdr(4'd1, 4'd0, 2'd2, 8'd0, 4'd5, 2'd1, 32'd0), M_ACK);
        send(mkhdr(4'd0, 4'd1, 2'd0, 8'd1, 4'd5, 2'd0, 32'd1023), 1'b0);
        send(DG, 1'b0);
        send(DF, 1'b1);
        wait_drain("wr_oob");
        vectors += 2;
        if (wr_cnt - w0 != 1) begin miscompares++; $display("FAIL wr_oob_count got=%0d required=1", wr_cnt - w0); end
        if (smem[1023] !== DG) begin miscompares++; $display("FAIL wr_oob_top got=%h required=%h", smem[1023], DG); end
        // Read ending exactly on the last word is in range.
        expect_flit(1'b0, mkhdr(4'd1, 4'd0, 2'd3, 8'd3, 4'd6, 2'd0, 32'd0), M_RD);
        expect_flit(1'b0, 64'd0, M_DATA);
        expect_flit(1'b0, 64'd0, M_DATA);
        expect_flit(1'b0, 64'd0, M_DATA);
        expect_flit(1'b1, DG, M_DATA);
        send(mkhdr(4'd0, 4'd1, 2'd1, 8'd3, 4'd6, 2'd0, 32'd1020), 1'b1);
        wait_drain("rd_top");
    endtask

    task automatic test_len_err();
        int w0;
        w0 = wr_cnt;
        expect_flit(1'b1, mkhdr(4'd5, 4'd0, 2'd2, 8'd0, 4'd1, 2'd2, 32'd0), M_ACK);
        send(mkhdr(4'd0, 4'd5, 2'd0, 8'd3, 4'd1, 2'd0, 32'd20), 1'b0);
        send(DE, 1'b0);
        send(DF, 1'b1);
        wait_drain("len_short");
        vectors += 2;
        if (wr_cnt - w0 != 2) begin miscompares++; $display("FAIL len_short_writes got=%0d required=2", wr_cnt - w0); end
        if (smem[22] !== 64'd0) begin miscompares++; $display("FAIL len_short_sram22 got=%h required=0", smem[22]); end
        expect_flit(1'b0, mkhdr(4'd5, 4'd0, 2'd3, 8'd1, 4'd2, 2'd0, 32'd0), M_RD);
        expect_flit(1'b0, DE, M_DATA);
        expect_flit(1'b1, DF, M_DATA);
        send(mkhdr(4'd0, 4'd5, 2'd1, 8'd1, 4'd2, 2'd0, 32'd20), 1'b1);
        wait_drain("len_next_rd");
        w0 = wr_cnt;
        expect_flit(1'b1, mkhdr(4'd6, 4'd0, 2'd2, 8'd0, 4'd3, 2'd2, 32'd0), M_ACK);
        send(mkhdr(4'd0, 4'd6, 2'd0, 8'd1, 4'd3, 2'd0, 32'd40), 1'b0);
        send(DA, 1'b0);
        send(DB, 1'b0);
        send(DC, 1'b1);
        wait_drain("len_long");
        vectors += 2;
        if (wr_cnt - w0 != 2) begin miscompares++; $display("FAIL len_long_writes got=%0d required=2", wr_cnt - w0); end
        if (smem[42] !== 64'd0) begin miscompares++; $display("FAIL len_long_sram42 got=%h required=0", smem[42]); end
    endtask

    task automatic test_back_to_back_drop();
        int c0;
        c0 = cyc;
        send(mkhdr(4'd1, 4'd2, 2'd0, 8'd2, 4'd0, 2'd0, 32'd7), 1'b0);
        send(DA, 1'b0);
        send(DB, 1'b0);
        send(DC, 1'b1);
        vectors++;
        if (drop_cnt !== 16'd1) begin miscompares++; $display("FAIL drop_cnt_first got=%0d required=1", drop_cnt); end
        send(mkhdr(4'd1, 4'd2, 2'd1, 8'd0, 4'd0, 2'd0, 32'd0), 1'b1);
        expect_flit(1'b0, mkhdr(4'd2, 4'd0, 2'd3, 8'd0, 4'd8, 2'd0, 32'd0), M_RD);
        expect_flit(1'b1, 64'd0, M_DATA);
        send(mkhdr(4'd0, 4'd2, 2'd1, 8'd0, 4'd8, 2'd0, 32'd0), 1'b1);
        vectors += 2;
        if (cyc - c0 != 6) begin miscompares++; $display("FAIL b2b_cycles got=%0d required=6", cyc - c0); end
        if (drop_cnt !== 16'd2) begin miscompares++; $display("FAIL drop_cnt_second got=%0d required=2", drop_cnt); end
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid_packet();
        send(mkhdr(4'd0, 4'd2, 2'd0, 8'd3, 4'd0, 2'd0, 32'd100), 1'b0);
        send(DB, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors += 2;
        if (rsp_if.tvalid !== 1'b0) begin miscompares++; $display("FAIL midrst_tvalid got=%b required=0", rsp_if.tvalid); end
        if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_drop_cnt got=%0d required=0", drop_cnt); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_flit(1'b0, mkhdr(4'd4, 4'd0, 2'd3, 8'd0, 4'd3, 2'd0, 32'd0), M_RD);
        expect_flit(1'b1, DA, M_DATA);
        send(mkhdr(4'd0, 4'd4, 2'd1, 8'd0, 4'd3, 2'd0, 32'd5), 1'b1);
        wait_drain("midrst_rd");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        wr_cnt = 0;
        en_cnt = 0;
        cyc = 0;
        tog = 1'b0;
        mem_rdata = 64'd0;
        test_reset();
        test_write();
        test_read_toggle();
        test_out_of_range();
        test_len_err();
        test_back_to_back_drop();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
